// File: rtl/gpu_pkg.sv
// Shared GPU core types: pipeline stage encoding, register write-source select
// and special register indices.
package gpu_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned ADDR_W        = 4;
  localparam int unsigned NUM_REGS      = 16;
  localparam int unsigned REG_BLOCK_ID  = 13;
  localparam int unsigned REG_BLOCK_DIM = 14;
  localparam int unsigned REG_THREAD_ID = 15;

  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    FETCH   = 3'b001,
    DECODE  = 3'b010,
    REQUEST = 3'b011,
    WAIT    = 3'b100,
    EXECUTE = 3'b101,
    UPDATE  = 3'b110,
    DONE    = 3'b111
  } core_state_t;

  typedef enum logic [1:0] {
    ARITHMETIC = 2'b00,
    MEMORY     = 2'b01,
    CONSTANT   = 2'b10
  } reg_input_mux_t;

endpackage

// File: rtl/registers_if.sv
// Thread register file bus: decoded instruction fields and datapath results in,
// registered operands out.
interface registers_if;
  import gpu_pkg::*;

  logic                enable;
  logic [DATA_W-1:0]   block_id;
  logic [2:0]          core_state;
  logic [ADDR_W-1:0]   decoded_rd_address;
  logic [ADDR_W-1:0]   decoded_rs_address;
  logic [ADDR_W-1:0]   decoded_rt_address;
  logic                decoded_reg_write_enable;
  logic [1:0]          decoded_reg_input_mux;
  logic [DATA_W-1:0]   decoded_immediate;
  logic [DATA_W-1:0]   alu_out;
  logic [DATA_W-1:0]   lsu_out;
  logic [DATA_W-1:0]   rs;
  logic [DATA_W-1:0]   rt;

  modport master (
    output enable, block_id, core_state,
    output decoded_rd_address, decoded_rs_address, decoded_rt_address,
    output decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
    output alu_out, lsu_out,
    input  rs, rt
  );

  modport slave (
    input  enable, block_id, core_state,
    input  decoded_rd_address, decoded_rs_address, decoded_rt_address,
    input  decoded_reg_write_enable, decoded_reg_input_mux, decoded_immediate,
    input  alu_out, lsu_out,
    output rs, rt
  );

endinterface

// File: rtl/registers.sv
// Per-thread 16 x 8-bit register file: R0..R12 general purpose, R13..R15 hold
// block id, block dimension and thread id and are never written by instructions.
module registers
  import gpu_pkg::*;
#(
  parameter int unsigned THREADS_PER_BLOCK = 4,
  parameter int unsigned THREAD_ID         = 0,
  parameter int unsigned DATA_BITS         = 8
) (
  input  logic         clock,
  input  logic         reset,
  registers_if.slave   bus
);

  localparam logic [ADDR_W-1:0] IDX_BLOCK_ID  = ADDR_W'(REG_BLOCK_ID);
  localparam logic [ADDR_W-1:0] IDX_BLOCK_DIM = ADDR_W'(REG_BLOCK_DIM);
  localparam logic [ADDR_W-1:0] IDX_THREAD_ID = ADDR_W'(REG_THREAD_ID);
  localparam logic [ADDR_W-1:0] IDX_LAST_GP   = ADDR_W'(REG_BLOCK_ID - 1);

  // Elaboration-time parameter sanity checks
  if (DATA_BITS != 8) begin : g_bad_data_bits
    $error("registers: only DATA_BITS == 8 is supported");
  end
  if (THREADS_PER_BLOCK < 1 || THREADS_PER_BLOCK > 255) begin : g_bad_tpb
    $error("registers: THREADS_PER_BLOCK must be 1..255");
  end
  if (THREAD_ID >= THREADS_PER_BLOCK) begin : g_bad_tid
    $error("registers: THREAD_ID must be below THREADS_PER_BLOCK");
  end

  logic [DATA_W-1:0] regs [NUM_REGS];

  logic [DATA_W-1:0] wr_data_c;
  logic              wr_src_ok_c;
  logic              wr_en_c;
  logic              rd_en_c;

  // Write-source select; the reserved encoding suppresses the write
  always_comb begin
    wr_data_c   = '0;
    wr_src_ok_c = 1'b0;
    case (bus.decoded_reg_input_mux)
      ARITHMETIC: begin wr_data_c = bus.alu_out;           wr_src_ok_c = 1'b1; end
      MEMORY:     begin wr_data_c = bus.lsu_out;           wr_src_ok_c = 1'b1; end
      CONSTANT:   begin wr_data_c = bus.decoded_immediate; wr_src_ok_c = 1'b1; end
      default:    begin wr_data_c = '0;                    wr_src_ok_c = 1'b0; end
    endcase
  end

  assign rd_en_c = bus.enable && (bus.core_state == REQUEST);
  assign wr_en_c = bus.enable && (bus.core_state == UPDATE) &&
                   bus.decoded_reg_write_enable && wr_src_ok_c &&
                   (bus.decoded_rd_address <= IDX_LAST_GP);

  // Array, operand latches and the per-cycle block id refresh
  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      regs[IDX_BLOCK_DIM] <= DATA_W'(THREADS_PER_BLOCK);
      regs[IDX_THREAD_ID] <= DATA_W'(THREAD_ID);
      bus.rs              <= '0;
      bus.rt              <= '0;
    end else if (bus.enable) begin
      regs[IDX_BLOCK_ID] <= bus.block_id;
      if (rd_en_c) begin
        bus.rs <= regs[bus.decoded_rs_address];
        bus.rt <= regs[bus.decoded_rt_address];
      end
      if (wr_en_c) begin
        regs[bus.decoded_rd_address] <= wr_data_c;
      end
    end
  end

endmodule
